pe_lp_stream: RTL

- Parametrised successor of the last-layer LP processing element.
- Consumes a valid/ready pixel+weight stream and reduces a window of len_in taps, either by fixed-point MAC plus bias, or by max-pool.
- Applies optional ReLU, saturates the result to WORD_BITS, and writes it to the local data memory store port at an auto-incrementing, wrapping address.
- Sits between the global-buffer broadcast and the LDM. Word width, fraction, accumulator width and store depth are generic.

---
 rtl/pe_lp_stream.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/pe_lp_stream.sv
// pe_lp_stream: reduces len_in taps by MAC+bias or max-pool, applies ReLU/saturation, stores to LDM (option PE_LP_STREAM_STRIDE2_EN).
// Latency: store strobe 2 enabled cycles after the last accepted beat; len+2 cycles per output.
// Backpressure: Pixel_ready_out is combinational; low in POST/WRITE, when disabled, when cleared and during reset.
module pe_lp_stream #(
    parameter int WORD_BITS = 16,
    parameter int FRAC_BITS = 8,
    parameter int ACC_BITS  = 40,
    parameter int ADDR_BITS = 6,
    parameter int LEN_BITS  = 4
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 En_in,
    input  logic                 layer_done_in,
    input  logic [1:0]           mode_in,
    input  logic                 relu_en_in,
    input  logic [LEN_BITS-1:0]  len_in,
    input  logic [ADDR_BITS-1:0] base_addr_in,
`ifdef PE_LP_STREAM_STRIDE2_EN
    input  logic                 Stride_in,
`endif
    input  logic                 Pixel_valid_in,
    input  logic [WORD_BITS-1:0] Pixel_in,
    input  logic [WORD_BITS-1:0] Weight_in,
    input  logic [WORD_BITS-1:0] Bias_in,
    output logic                 Pixel_ready_out,
    output logic                 Store_en_out,
    output logic [ADDR_BITS-1:0] Store_addr_out,
    output logic [WORD_BITS-1:0] Store_data_out,
    output logic                 Busy_out,
    output logic [ADDR_BITS:0]   Count_out
);

    typedef enum logic [1:0] {S_IDLE, S_ACC, S_POST, S_WRITE} state_t;

    typedef struct packed {
`ifdef PE_LP_STREAM_STRIDE2_EN
        logic                stride;
`endif
        logic                mp;
        logic                relu;
        logic [LEN_BITS-1:0] len;
    } cfg_t;

    localparam logic signed [ACC_BITS-1:0] SAT_MAX =
        {{(ACC_BITS-WORD_BITS+1){1'b0}}, {(WORD_BITS-1){1'b1}}};
    localparam logic signed [ACC_BITS-1:0] SAT_MIN =
        {{(ACC_BITS-WORD_BITS+1){1'b1}}, {(WORD_BITS-1){1'b0}}};

    state_t                        state, state_nxt;
    cfg_t                          cfg;
    logic signed [ACC_BITS-1:0]    acc;
    logic [LEN_BITS-1:0]           tap_cnt;
    logic [ADDR_BITS-1:0]          wptr;
    logic                          beat;
    logic                          skip_wr;
    logic [LEN_BITS-1:0]           len_eff;
    logic [LEN_BITS:0]             tap_inc;
    logic signed [2*WORD_BITS-1:0] prod;
    logic signed [ACC_BITS-1:0]    prod_ext, pix_ext, bias_ext, post_sum, post_r;
    logic [WORD_BITS-1:0]          sat_dat;

`ifdef PE_LP_STREAM_STRIDE2_EN
    logic phase;
    assign skip_wr = cfg.stride & phase;
`else
    assign skip_wr = 1'b0;
`endif

    assign Busy_out       = (state != S_IDLE);
    assign Store_addr_out = base_addr_in + wptr;

    // Arithmetic: full-width signed product, post-processing of the finished window.
    always_comb begin
        len_eff  = (len_in == '0) ? LEN_BITS'(1) : len_in;
        tap_inc  = {1'b0, tap_cnt} + (LEN_BITS+1)'(1);
        prod     = $signed({{WORD_BITS{Pixel_in[WORD_BITS-1]}}, Pixel_in})
                 * $signed({{WORD_BITS{Weight_in[WORD_BITS-1]}}, Weight_in});
        prod_ext = {{(ACC_BITS-2*WORD_BITS){prod[2*WORD_BITS-1]}}, prod};
        pix_ext  = {{(ACC_BITS-WORD_BITS){Pixel_in[WORD_BITS-1]}}, Pixel_in};
        bias_ext = {{(ACC_BITS-WORD_BITS){Bias_in[WORD_BITS-1]}}, Bias_in};
        post_sum = acc + (bias_ext <<< FRAC_BITS);
        if (cfg.mp) begin
            post_r = acc;
        end else begin
            post_r = post_sum >>> FRAC_BITS;
        end
        if (cfg.relu && post_r[ACC_BITS-1]) begin
            post_r = '0;
        end
        if (post_r > SAT_MAX) begin
            sat_dat = SAT_MAX[WORD_BITS-1:0];
        end else if (post_r < SAT_MIN) begin
            sat_dat = SAT_MIN[WORD_BITS-1:0];
        end else begin
            sat_dat = post_r[WORD_BITS-1:0];
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        Pixel_ready_out = En_in & ~layer_done_in & ~RST & ((state == S_IDLE) | (state == S_ACC));
        beat            = Pixel_ready_out & Pixel_valid_in;
        Store_en_out    = En_in & ~layer_done_in & (state == S_WRITE);
        if (layer_done_in) begin
            state_nxt = S_IDLE;
        end else if (En_in) begin
            case (state)
                S_IDLE:  if (beat) state_nxt = (len_eff <= LEN_BITS'(1)) ? S_POST : S_ACC;
                S_ACC:   if (beat && (tap_inc >= {1'b0, cfg.len})) state_nxt = S_POST;
                S_POST:  state_nxt = skip_wr ? S_IDLE : S_WRITE;
                S_WRITE: state_nxt = S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cfg            <= '0;
            acc            <= '0;
            tap_cnt        <= '0;
            wptr           <= '0;
            Count_out      <= '0;
            Store_data_out <= '0;
`ifdef PE_LP_STREAM_STRIDE2_EN
            phase          <= 1'b0;
`endif
        end else if (layer_done_in) begin
            acc       <= '0;
            tap_cnt   <= '0;
            wptr      <= '0;
            Count_out <= '0;
`ifdef PE_LP_STREAM_STRIDE2_EN
            phase     <= 1'b0;
`endif
        end else if (En_in) begin
            case (state)
                S_IDLE: begin
                    if (beat) begin
                        cfg.mp   <= |mode_in;
                        cfg.relu <= relu_en_in;
                        cfg.len  <= len_eff;
`ifdef PE_LP_STREAM_STRIDE2_EN
                        cfg.stride <= Stride_in;
`endif
                        acc      <= (|mode_in) ? pix_ext : prod_ext;
                        tap_cnt  <= LEN_BITS'(1);
                    end
                end
                S_ACC: begin
                    if (beat) begin
                        if (cfg.mp) begin
                            if (pix_ext > acc) acc <= pix_ext;
                        end else begin
                            acc <= acc + prod_ext;
                        end
                        tap_cnt <= tap_inc[LEN_BITS-1:0];
                    end
                end
                S_POST: begin
                    if (!skip_wr) Store_data_out <= sat_dat;
`ifdef PE_LP_STREAM_STRIDE2_EN
                    phase <= ~phase;
`endif
                end
                S_WRITE: begin
                    wptr <= wptr + ADDR_BITS'(1);
                    if (Count_out != '1) Count_out <= Count_out + (ADDR_BITS+1)'(1);
                end
                default: ;
            endcase
        end
    end

endmodule
